nibble_serial_add_ctrl: RTL and testbench
=========================================

// Module: nibble_serial_add_ctrl
// PURPOSE
//  Sequencer that runs a WIDTH-bit add or subtract through one shared 4-bit ripple adder slice (fa_4bit_st).
//  The slice does one nibble per clock, LSB nibble first, with the carry held in a register between nibbles.
//  A start/busy/done handshake lets a host trade latency for area on wide operands.
//  Sits between the host register file and the adder slice; it is the only driver of the slice inputs.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be a multiple of 4 and >= 8; N = WIDTH/4 nibbles
// PORTS
//  clk    in   1      single clock; all state changes on rising edge
//  rst    in   1      synchronous, active-high reset
//  start  in   1      request; sampled only when state != RUN
//  sub    in   1      0 = a+b, 1 = a-b; sampled with start
//  a      in   WIDTH  operand A; sampled with start
//  b      in   WIDTH  operand B; sampled with start
//  busy   out  1      high while state == RUN
//  done   out  1      one-cycle pulse: result valid
//  sum    out  WIDTH  result register
//  cout   out  1      final carry out (sub: 1 = no borrow, i.e. a >= b unsigned)
//  ovf    out  1      two's-complement signed overflow of the full WIDTH result
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; nibble index and carry register = 0.
//  FSM states IDLE, RUN, DONE.
//   IDLE/DONE + start=1 -> RUN:
//    latch opA=a and opB = sub ? ~b : b; carry=sub; idx=0; sum cleared to 0.
//   IDLE + start=0 -> IDLE.
//   DONE + start=0 -> IDLE.
//   RUN, each cycle:
//    slice inputs = opA[4*idx+:4], opB[4*idx+:4], carry.
//    On the edge: sum[4*idx+:4] <= slice sum; carry <= slice cout; idx <= idx+1.
//   RUN with idx == N-1 -> DONE on that edge:
//    cout <= slice cout;
//    ovf <= (opA[WIDTH-1] == opB[WIDTH-1]) && (final sum MSB != opA[WIDTH-1]).
//  done = (state == DONE), exactly one cycle. busy = (state == RUN).
//  Latency: start accepted on edge E; done is high in the cycle following edge E+N.
//   For WIDTH=16: 4 RUN cycles plus the DONE cycle.
//  start while busy: ignored, no effect on the operation in flight; a, b and sub are not re-sampled.
//  Back-to-back: start in the DONE cycle is accepted. The next RUN begins with no IDLE gap and sum is cleared.
//  sum/cout/ovf hold their values from DONE until the next accepted start. They are 0 after reset.
//  Partial nibbles of sum are visible during RUN; consumers use sum only when done=1 or later.
//  rst during RUN: abort immediately; every output returns to its reset value on that edge; no done pulse.
//  rst has priority over start on the same edge.
//  Carry chain: the internal width is exactly WIDTH. Wrap-around is modulo 2^WIDTH; the carry beyond bit WIDTH-1 appears only on cout.
// TESTING (WIDTH=16)
//  add 0x1234+0x0FCD -> done on the 4th edge after the start edge; sum=0x2201, cout=0, ovf=0
//  add 0xFFFF+0x0001 -> sum=0x0000, cout=1, ovf=0. add 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1
//  sub 0x0005-0x0007 -> sum=0xFFFE, cout=0, ovf=0. sub 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1
//  0x1111+0x2222, then start=1 with 0xFFFF/0xFFFF during RUN -> sum=0x3333; no extra done pulse
//  Start held high through DONE: op2 0x00FF+0x0001 accepted in the DONE cycle -> second done after 4 more RUN cycles; sum=0x0100
//  rst asserted in the 2nd RUN cycle -> next cycle busy=0, done=0, sum=0, cout=0, ovf=0; no done pulse follows

Source files
------------

// File: rtl/nibble_serial_add_ctrl_if.sv
// Host-side handshake bundle for the nibble-serial adder sequencer.
// The host drives the request and operands; the sequencer returns status and result.
interface nibble_serial_add_ctrl_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output start, sub, a, b,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, sub, a, b,
      output busy, done, sum, cout, ovf
   );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit add/subtract sequenced one nibble per clock through a shared 4-bit slice.
// Subtraction is a + ~b + 1, with the +1 entering as the initial carry.

module fa_4bit_st (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);
   logic [4:0] total;

   assign total = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
   assign sum   = total[3:0];
   assign cout  = total[4];
endmodule

// state | meaning
// IDLE  | waiting for start
// RUN   | one nibble per clock, LSB nibble first
// DONE  | result valid for one cycle; start here begins the next operation
module nibble_serial_add_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   nibble_serial_add_ctrl_if.slave  bus
);
   localparam int N  = WIDTH / 4;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             carry;
   logic [IW-1:0]    idx;

   logic [3:0] sl_a;
   logic [3:0] sl_b;
   logic [3:0] sl_sum;
   logic       sl_cout;

   always_comb begin
      sl_a = op_a[4*idx +: 4];
      sl_b = op_b[4*idx +: 4];
   end

   fa_4bit_st u_slice (
      .a    (sl_a),
      .b    (sl_b),
      .cin  (carry),
      .sum  (sl_sum),
      .cout (sl_cout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         op_a     <= '0;
         op_b     <= '0;
         carry    <= 1'b0;
         idx      <= '0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.sum  <= '0;
         bus.cout <= 1'b0;
         bus.ovf  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  state    <= RUN;
                  op_a     <= bus.a;
                  op_b     <= bus.sub ? ~bus.b : bus.b;
                  carry    <= bus.sub;
                  idx      <= '0;
                  bus.sum  <= '0;
                  bus.busy <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               bus.sum[4*idx +: 4] <= sl_sum;
               carry               <= sl_cout;
               idx                 <= idx + 1'b1;
               if (idx == LAST) begin
                  state    <= DONE;
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
                  bus.cout <= sl_cout;
                  // signed overflow: like-signed operands whose result sign flips
                  bus.ovf  <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                              (sl_sum[3] != op_a[WIDTH-1]);
               end
            end
            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
               bus.done <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Randomized scoreboard bench for nibble_serial_add_ctrl at WIDTH=16.
module tb_nibble_serial_add_ctrl;
   localparam int W = 16;
   localparam int N = W / 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   nibble_serial_add_ctrl_if #(.WIDTH(W)) bus ();

   nibble_serial_add_ctrl #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      int           t;
   } exp_t;

   exp_t         q[$];
   int           checks    = 0;
   int           failures  = 0;
   int           cyc       = 0;
   int           n_pushed  = 0;
   int           n_done    = 0;
   logic         have_last = 1'b0;
   logic [W-1:0] last_sum;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Reference: plain modular and signed arithmetic on the whole operands.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      exp_t       e;
      int         sa, sb, sr;
      logic [W:0] u;
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sub) begin
         u      = {1'b0, a} - {1'b0, b};
         e.cout = (a >= b);
         sr     = sa - sb;
      end else begin
         u      = {1'b0, a} + {1'b0, b};
         e.cout = u[W];
         sr     = sa + sb;
      end
      e.sum = u[W-1:0];
      e.ovf = (sr > 32767) || (sr < -32768);
      e.t   = 0;
      return e;
   endfunction

   // Monitor: pops an expectation whenever done is presented.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.done) begin
            n_done++;
            if (q.size() == 0) begin
               check("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("sum",     32'(bus.sum),  32'(e.sum));
               check("cout",    32'(bus.cout), 32'(e.cout));
               check("ovf",     32'(bus.ovf),  32'(e.ovf));
               check("latency", 32'(cyc - e.t), 32'(N));
               check("busy_at_done", 32'(bus.busy), 32'd0);
               last_sum  = e.sum;
               have_last = 1'b1;
            end
         end else if (!bus.busy && have_last) begin
            check("sum_hold", 32'(bus.sum), 32'(last_sum));
         end
      end
   end

   task automatic wait_idle();
      int k;
      k = 0;
      @(negedge clk);
      while (bus.busy && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (bus.busy) check("wait_idle_timeout", 32'(bus.busy), 32'd0);
   endtask

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input bit track);
      exp_t e;
      wait_idle();
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      bus.sub   = sub;
      @(posedge clk);
      #1;
      if (track) begin
         e   = model(a, b, sub);
         e.t = cyc;
         q.push_back(e);
         n_pushed++;
      end
      bus.start = 1'b0;
   endtask

   initial begin
      int k;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.sub   = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_sum",  32'(bus.sum),  32'd0);
      check("rst_cout", 32'(bus.cout), 32'd0);
      check("rst_ovf",  32'(bus.ovf),  32'd0);
      rst = 1'b0;

      issue(16'h1234, 16'h0FCD, 1'b0, 1'b1);
      issue(16'hFFFF, 16'h0001, 1'b0, 1'b1);
      issue(16'h7FFF, 16'h0001, 1'b0, 1'b1);
      issue(16'h0005, 16'h0007, 1'b1, 1'b1);
      issue(16'h8000, 16'h0001, 1'b1, 1'b1);

      // start pulses during RUN must be ignored
      issue(16'h1111, 16'h2222, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.start = 1'b1;
         bus.a     = 16'hFFFF;
         bus.b     = 16'hFFFF;
         bus.sub   = 1'b1;
      end
      @(negedge clk);
      bus.start = 1'b0;

      // start held high through DONE: second op accepted in the DONE cycle
      wait_idle();
      bus.start = 1'b1;
      bus.a     = 16'h0F0F;
      bus.b     = 16'h0101;
      bus.sub   = 1'b0;
      @(posedge clk);
      #1;
      begin
         exp_t e;
         e   = model(16'h0F0F, 16'h0101, 1'b0);
         e.t = cyc;
         q.push_back(e);
         n_pushed++;
      end
      bus.a = 16'hFFFF;
      bus.b = 16'hFFFF;
      k = 0;
      @(negedge clk);
      while (!bus.done && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("hold_done_seen", 32'(bus.done), 32'd1);
      bus.a   = 16'h00FF;
      bus.b   = 16'h0001;
      bus.sub = 1'b0;
      @(posedge clk);
      #1;
      begin
         exp_t e;
         e   = model(16'h00FF, 16'h0001, 1'b0);
         e.t = cyc;
         q.push_back(e);
         n_pushed++;
      end
      check("b2b_busy", 32'(bus.busy), 32'd1);
      check("b2b_sum_cleared", 32'(bus.sum), 32'd0);
      bus.start = 1'b0;

      // reset in the second RUN cycle aborts the operation
      issue(16'h1234, 16'h0FCD, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      have_last = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      check("abort_sum",  32'(bus.sum),  32'd0);
      check("abort_cout", 32'(bus.cout), 32'd0);
      check("abort_ovf",  32'(bus.ovf),  32'd0);
      repeat (8) @(negedge clk);

      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] ra, rb;
         ra = W'($urandom);
         rb = W'($urandom);
         case ($urandom_range(0, 5))
            0: ra = 16'h7FFF;
            1: rb = 16'h8000;
            2: rb = ra;
            default: ;
         endcase
         issue(ra, rb, 1'($urandom_range(0, 1)), 1'b1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      k = 0;
      while (q.size() != 0 && k < 30) begin
         @(negedge clk);
         k++;
      end
      repeat (3) @(negedge clk);
      check("drain_empty", 32'(q.size()), 32'd0);
      check("done_count", 32'(n_done), 32'(n_pushed));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
